// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the scoreboard-based hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        CLASS_ALU    = 2'd0,
        CLASS_LOAD   = 2'd1,
        CLASS_MULDIV = 2'd2,
        CLASS_RSVD   = 2'd3
    } op_class_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int unsigned MIN_LAT = 2;

    function automatic int unsigned lat_clamp(
        input int unsigned lat,
        input int unsigned max_lat
    );
        if (lat < MIN_LAT) return MIN_LAT;
        if (lat > max_lat) return max_lat;
        return lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side control bundle between the decode stage and the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int LAT_W        = 4
);
    logic                               ID_Valid;
    logic [NUM_RD_PORTS*REG_ADDR_W-1:0] ID_Rs;
    logic [NUM_RD_PORTS-1:0]            ID_Rs_Used;
    logic                               ID_RegWrite;
    logic [REG_ADDR_W-1:0]              ID_Rd;
    logic [1:0]                         ID_Class;
    logic [LAT_W-1:0]                   ID_Latency;
    logic                               Flush;
    logic                               Issue;
    logic                               PC_Enable;
    logic                               IF_ID_Enable;
    logic                               ID_Control_NOP;
    logic [2*NUM_RD_PORTS-1:0]          Fwd_Sel_EX;
    logic                               Pending_Any;

    modport master (
        output ID_Valid, ID_Rs, ID_Rs_Used, ID_RegWrite,
        output ID_Rd, ID_Class, ID_Latency, Flush,
        input  Issue, PC_Enable, IF_ID_Enable,
        input  ID_Control_NOP, Fwd_Sel_EX, Pending_Any
    );

    modport slave (
        input  ID_Valid, ID_Rs, ID_Rs_Used, ID_RegWrite,
        input  ID_Rd, ID_Class, ID_Latency, Flush,
        output Issue, PC_Enable, IF_ID_Enable,
        output ID_Control_NOP, Fwd_Sel_EX, Pending_Any
    );
endinterface

// File: rtl/hazard_sb_entry.sv
// One tracked register: cycles until writeback plus a not-from-EX/MEM flag.
module hazard_sb_entry #(
    parameter int LAT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load_i,
    input  logic [LAT_W-1:0] lat_i,
    input  logic             late_i,
    input  logic             clr_i,
    output logic [LAT_W-1:0] rem_o,
    output logic             late_o
);
    logic [LAT_W-1:0] rem_q, rem_d;
    logic             late_q, late_d;

    always_comb begin
        rem_d  = rem_q;
        late_d = late_q;
        if (clr_i) begin
            rem_d  = '0;
            late_d = 1'b0;
        end else if (load_i) begin
            rem_d  = lat_i;
            late_d = late_i;
        end else if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == LAT_W'(1)) late_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rem_q  <= '0;
            late_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            late_q <= late_d;
        end
    end

    assign rem_o  = rem_q;
    assign late_o = late_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register countdowns, issue/stall decision
// and registered EX forward selects for every read port.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int MAX_LAT      = 8,
    parameter int LAT_W        = $clog2(MAX_LAT + 1)
) (
    input logic               Clk,
    input logic               Reset_n,
    hazard_scoreboard_if.slave bus
);
    localparam int               NREG   = 1 << REG_ADDR_W;
    localparam logic [LAT_W-1:0] L_BASE = LAT_W'(MIN_LAT);

    logic [LAT_W-1:0]                rem [NREG];
    logic [NREG-1:0]                 late;
    logic [MAX_LAT:1]                wbr_q, wbr_d, wbr_sh;
    logic [REG_ADDR_W-1:0]           last_rd_q, last_rd_d;
    logic [LAT_W-1:0]                last_lat_q, last_lat_d;
    logic                            last_vld_q, last_vld_d;
    logic [2*NUM_RD_PORTS-1:0]       fwd_q, fwd_d;
    logic [NUM_RD_PORTS-1:0][1:0]    sel;
    logic [NUM_RD_PORTS-1:0]         port_haz;
    logic [LAT_W-1:0]                lat_eff;
    logic                            waw, wbp, stall, issue;
    logic                            issue_wr, clr_last, pend;

    assign rem[0]  = '0;
    assign late[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .load_i  (issue_wr && bus.ID_Rd == REG_ADDR_W'(r)),
            .lat_i   (lat_eff),
            .late_i  (bus.ID_Class == CLASS_LOAD),
            .clr_i   (clr_last && last_rd_q == REG_ADDR_W'(r)),
            .rem_o   (rem[r]),
            .late_o  (late[r])
        );
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [REG_ADDR_W-1:0] rs;
        logic [LAT_W-1:0]      rrem;
        logic                  rlate, chk, haz_l;
        logic [1:0]            sel_l;

        assign rs    = bus.ID_Rs[p*REG_ADDR_W +: REG_ADDR_W];
        assign rrem  = rem[rs];
        assign rlate = late[rs];
        assign chk   = bus.ID_Rs_Used[p] && rs != '0;

        // Rem==2 means the producer sits in EX now; a load there is too late.
        always_comb begin
            haz_l = 1'b0;
            sel_l = FWD_RF;
            if (chk) begin
                if (rrem >= LAT_W'(3)) begin
                    haz_l = 1'b1;
                end else if (rrem == L_BASE) begin
                    if (rlate) haz_l = 1'b1;
                    else       sel_l = FWD_EXMEM;
                end else if (rrem == LAT_W'(1)) begin
                    sel_l = FWD_MEMWB;
                end
            end
        end

        assign port_haz[p] = haz_l;
        assign sel[p]      = sel_l;
    end

    always_comb begin
        if (bus.ID_Class == CLASS_MULDIV)
            lat_eff = LAT_W'(lat_clamp(32'(bus.ID_Latency), MAX_LAT));
        else
            lat_eff = L_BASE;
    end

    always_comb begin
        wbr_sh   = wbr_q >> 1;
        waw      = bus.ID_RegWrite && bus.ID_Rd != '0
                   && rem[bus.ID_Rd] > lat_eff;
        wbp      = bus.ID_RegWrite && wbr_sh[lat_eff];
        stall    = bus.ID_Valid && (|port_haz || waw || wbp) && !bus.Flush;
        issue    = bus.ID_Valid && !stall && !bus.Flush;
        issue_wr = issue && bus.ID_RegWrite && bus.ID_Rd != '0;
        clr_last = bus.Flush && last_vld_q;

        // Flushed op was one edge into its countdown: its slot is now L-1.
        wbr_d = wbr_sh;
        if (issue_wr) wbr_d[lat_eff] = 1'b1;
        if (clr_last) wbr_d[last_lat_q - 1'b1] = 1'b0;

        last_vld_d = issue_wr;
        last_rd_d  = bus.ID_Rd;
        last_lat_d = lat_eff;
        fwd_d      = issue ? sel : '0;
    end

    always_comb begin
        pend = 1'b0;
        for (int r = 0; r < NREG; r++) pend = pend | (rem[r] != '0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wbr_q      <= '0;
            last_rd_q  <= '0;
            last_lat_q <= '0;
            last_vld_q <= 1'b0;
            fwd_q      <= '0;
        end else begin
            wbr_q      <= wbr_d;
            last_rd_q  <= last_rd_d;
            last_lat_q <= last_lat_d;
            last_vld_q <= last_vld_d;
            fwd_q      <= fwd_d;
        end
    end

    assign bus.Issue          = issue;
    assign bus.PC_Enable      = !stall;
    assign bus.IF_ID_Enable   = !stall;
    assign bus.ID_Control_NOP = stall | bus.Flush;
    assign bus.Fwd_Sel_EX     = fwd_q;
    assign bus.Pending_Any    = pend;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with a queued-expectation monitor.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int AW = 5;
    localparam int NP = 2;
    localparam int ML = 8;
    localparam int LW = 4;

    logic Clk = 1'b0;
    logic Reset_n;

    hazard_scoreboard_if #(
        .REG_ADDR_W(AW), .NUM_RD_PORTS(NP), .LAT_W(LW)
    ) bus ();

    hazard_scoreboard #(
        .REG_ADDR_W(AW), .NUM_RD_PORTS(NP), .MAX_LAT(ML)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // exp = {Issue, PC_Enable, IF_ID_Enable, ID_Control_NOP, Pending_Any, Fwd_Sel_EX}
    typedef struct {
        string      nm;
        logic [8:0] exp;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    logic [8:0] act;
    int         passed = 0;
    int         total  = 0;

    initial begin
        forever begin
            @(negedge Clk);
            if (q.size() != 0) begin
                me  = q.pop_front();
                act = {bus.Issue, bus.PC_Enable, bus.IF_ID_Enable,
                       bus.ID_Control_NOP, bus.Pending_Any, bus.Fwd_Sel_EX};
                total++;
                if (act === me.exp) passed++;
                else $display("FAIL %s: got iss/pc/ifid/nop/pend/fwd=%b required %b",
                              me.nm, act, me.exp);
            end
        end
    end

    task automatic cyc(
        input string      nm,
        input bit         rn,
        input bit         v,
        input logic [4:0] r0,
        input logic [4:0] r1,
        input logic [1:0] u,
        input bit         rw,
        input logic [4:0] rd,
        input logic [1:0] cl,
        input logic [3:0] lt,
        input bit         fl,
        input bit         e_iss,
        input bit         e_stl,
        input logic [3:0] e_fwd,
        input bit         e_pnd
    );
        exp_t e;
        @(posedge Clk);
        #1;
        Reset_n         = rn;
        bus.ID_Valid    = v;
        bus.ID_Rs       = {r1, r0};
        bus.ID_Rs_Used  = u;
        bus.ID_RegWrite = rw;
        bus.ID_Rd       = rd;
        bus.ID_Class    = cl;
        bus.ID_Latency  = lt;
        bus.Flush       = fl;
        e.nm  = nm;
        e.exp = {e_iss, !e_stl, !e_stl, e_stl | fl, e_pnd, e_fwd};
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [3:0] f, input bit p);
        cyc(nm, 1, 0, 0, 0, 2'b00, 0, 0, CLASS_ALU, 0, 0, 0, 0, f, p);
    endtask

    initial begin
        Reset_n         = 1'b1;
        bus.ID_Valid    = 1'b0;
        bus.ID_Rs       = '0;
        bus.ID_Rs_Used  = '0;
        bus.ID_RegWrite = 1'b0;
        bus.ID_Rd       = '0;
        bus.ID_Class    = CLASS_ALU;
        bus.ID_Latency  = '0;
        bus.Flush       = 1'b0;
        #2 Reset_n = 1'b0;

        cyc("rst_out", 0, 1, 0, 0, 2'b00, 1, 3, CLASS_ALU, 0, 0, 1, 0, 4'h0, 0);
        idle("rst_rel", 4'h0, 0);

        cyc("alu_r3", 1, 1, 0, 0, 2'b00, 1, 3, CLASS_ALU, 0, 0, 1, 0, 4'h0, 0);
        cyc("r3_exmem", 1, 1, 3, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'h0, 1);
        cyc("r3_memwb", 1, 1, 3, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'b0010, 1);
        cyc("r3_rf", 1, 1, 3, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'b0001, 0);

        cyc("ld_r5", 1, 1, 0, 0, 2'b00, 1, 5, CLASS_LOAD, 0, 0, 1, 0, 4'b0000, 0);
        cyc("ld_use_stall", 1, 1, 0, 5, 2'b10, 0, 0, CLASS_ALU, 0, 0, 0, 1, 4'h0, 1);
        cyc("ld_use_iss", 1, 1, 0, 5, 2'b10, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'h0, 1);
        idle("ld_use_fwd", 4'b0100, 0);

        cyc("mul6_r7", 1, 1, 0, 0, 2'b00, 1, 7, CLASS_MULDIV, 6, 0, 1, 0, 4'h0, 0);
        for (int i = 0; i < 4; i++)
            cyc("mul6_stall", 1, 1, 7, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 0, 1, 4'h0, 1);
        cyc("mul6_iss", 1, 1, 7, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'h0, 1);
        idle("mul6_fwd", 4'b0010, 1);
        idle("mul6_done", 4'h0, 0);

        cyc("mul4_r8", 1, 1, 0, 0, 2'b00, 1, 8, CLASS_MULDIV, 4, 0, 1, 0, 4'h0, 0);
        idle("mul4_gap", 4'h0, 1);
        cyc("wbp_stall", 1, 1, 0, 0, 2'b00, 1, 10, CLASS_ALU, 0, 0, 0, 1, 4'h0, 1);
        cyc("wbp_iss", 1, 1, 0, 0, 2'b00, 1, 10, CLASS_ALU, 0, 0, 1, 0, 4'h0, 1);
        idle("wbp_p1", 4'h0, 1);
        idle("wbp_p2", 4'h0, 1);
        idle("wbp_p3", 4'h0, 0);

        cyc("mul5_r7", 1, 1, 0, 0, 2'b00, 1, 7, CLASS_MULDIV, 5, 0, 1, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++)
            cyc("waw_stall", 1, 1, 0, 0, 2'b00, 1, 7, CLASS_ALU, 0, 0, 0, 1, 4'h0, 1);
        cyc("waw_iss", 1, 1, 0, 0, 2'b00, 1, 7, CLASS_ALU, 0, 0, 1, 0, 4'h0, 1);
        idle("waw_ovr1", 4'h0, 1);
        idle("waw_ovr2", 4'h0, 1);
        idle("waw_done", 4'h0, 0);

        cyc("ld_r9", 1, 1, 0, 0, 2'b00, 1, 9, CLASS_LOAD, 0, 0, 1, 0, 4'h0, 0);
        cyc("flush_r9", 1, 1, 9, 0, 2'b01, 0, 0, CLASS_ALU, 0, 1, 0, 0, 4'h0, 1);
        cyc("post_flush", 1, 1, 9, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'h0, 0);
        idle("post_fl_fwd", 4'h0, 0);

        cyc("alu_r12", 1, 1, 0, 0, 2'b00, 1, 12, CLASS_ALU, 0, 0, 1, 0, 4'h0, 0);
        cyc("ld_r11", 1, 1, 12, 0, 2'b01, 1, 11, CLASS_LOAD, 0, 0, 1, 0, 4'h0, 1);
        cyc("flush_stall", 1, 1, 11, 0, 2'b01, 0, 0, CLASS_ALU, 0, 1, 0, 0, 4'b0010, 1);
        idle("flush_fwd0", 4'h0, 0);

        cyc("mul7_r13", 1, 1, 0, 0, 2'b00, 1, 13, CLASS_MULDIV, 7, 0, 1, 0, 4'h0, 0);
        idle("mul7_a", 4'h0, 1);
        idle("mul7_b", 4'h0, 1);
        cyc("r13_stall", 1, 1, 13, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 0, 1, 4'h0, 1);
        cyc("rst_mid", 0, 1, 13, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'h0, 0);
        cyc("rst_after", 1, 1, 13, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'h0, 0);
        idle("rst_idle", 4'h0, 0);

        cyc("clamp_hi", 1, 1, 0, 0, 2'b00, 1, 14, CLASS_MULDIV, 15, 0, 1, 0, 4'h0, 0);
        for (int i = 0; i < 6; i++)
            cyc("clamp_hi_stall", 1, 1, 0, 14, 2'b10, 0, 0, CLASS_ALU, 0, 0, 0, 1, 4'h0, 1);
        cyc("clamp_hi_iss", 1, 1, 0, 14, 2'b10, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'h0, 1);
        idle("clamp_hi_fwd", 4'b1000, 1);
        idle("clamp_hi_done", 4'h0, 0);

        cyc("clamp_lo", 1, 1, 0, 0, 2'b00, 1, 15, CLASS_MULDIV, 1, 0, 1, 0, 4'h0, 0);
        cyc("clamp_lo_iss", 1, 1, 15, 0, 2'b01, 0, 0, CLASS_ALU, 0, 0, 1, 0, 4'h0, 1);
        idle("clamp_lo_fwd", 4'b0010, 1);
        idle("clamp_lo_done", 4'h0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge Clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, scoreboard-based successor to the pipeline hazard unit.
- Tracks every in-flight register write with a per-register countdown, so it supports multi-cycle producers (MUL/DIV) alongside ALU and load ops.
- Decides issue from ID into EX and generates the stall controls.
- Produces registered EX-stage forward selects for any number of read ports.
- Sits beside the ID stage and drives the PC, IF/ID enable, ID/EX NOP and the EX forwarding muxes.

Parameters:
- REG_ADDR_W, 5: register address width; tracks 2^REG_ADDR_W registers, r0 never tracked.
- NUM_RD_PORTS, 2: source operand ports checked per ID instruction.
- MAX_LAT, 8: maximum producer latency in cycles, issue to writeback; must be >= 2.
- LAT_W, clog2(MAX_LAT+1): countdown width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ID_Valid  in  1  valid instruction in ID.
- ID_Rs  in  NUM_RD_PORTS*REG_ADDR_W  source register per port, port 0 in the LSBs.
- ID_Rs_Used  in  NUM_RD_PORTS  per-port operand-used flag.
- ID_RegWrite  in  1  ID instruction writes a register.
- ID_Rd  in  REG_ADDR_W  destination register.
- ID_Class  in  2  0=ALU, 1=LOAD, 2=MULDIV, 3=reserved (treated as ALU).
- ID_Latency  in  LAT_W  cycles to writeback; used only for MULDIV; ALU and LOAD use 2.
- Flush  in  1  kill the instruction in EX and the instruction in ID.
- Issue  out  1  ID instruction advances to EX this cycle.
- PC_Enable  out  1  = !Stall.
- IF_ID_Enable  out  1  = !Stall.
- ID_Control_NOP  out  1  = Stall | Flush.
- Fwd_Sel_EX  out  2*NUM_RD_PORTS  registered EX forward select per port: 00 register file, 10 EX/MEM, 01 MEM/WB.
- Pending_Any  out  1  any tracked write still outstanding.

Behaviour:
- Per-register state, r1..r(2^REG_ADDR_W-1):
  - Rem: LAT_W bits; 0 means idle.
  - Late: 1 bit; result is not available from EX/MEM.
- Effective latency L:
  - ALU and LOAD: 2.
  - MULDIV: ID_Latency clamped to [2, MAX_LAT].
- Writeback reservation vector WBR[MAX_LAT:1]: bit k set means a write completes k cycles from now. It shifts down by 1 each cycle.
- Per used port p with Rs != 0, the combinational check in ID uses Rem/Late of Rs:
  - Rem >= 3: hazard.
  - Rem == 2 and Late: hazard (load-use bubble).
  - Rem == 2 and !Late: next select 10.
  - Rem == 1: next select 01.
  - Rem == 0: next select 00.
  - Unused port or Rs == 0: select 00, no hazard.
- WAW hazard: ID_RegWrite, ID_Rd != 0, and Rem(ID_Rd) > L.
- WB-port hazard: ID_RegWrite and WBR[L] set after this cycle's shift, i.e. two writebacks would land in the same cycle.
- Stall = ID_Valid & (any port hazard | WAW | WB-port) & !Flush.
- Issue = ID_Valid & !Stall & !Flush.
- Every edge:
  - Each nonzero Rem decrements.
  - Late clears when Rem reaches 0.
  - WBR shifts.
- On an Issue edge with ID_RegWrite and ID_Rd != 0:
  - Rem(ID_Rd) <= L.
  - Late <= (Class == LOAD).
  - WBR[L] set.
  - The new value overrides the same-cycle decrement.
- Fwd_Sel_EX loads the computed selects on an Issue edge, and loads 0 on a Stall or Flush edge.
- Flush:
  - Clears the entry written by the previous cycle's issue: a last-issue Rd and valid register are kept.
  - Clears that entry's WBR bit.
  - Suppresses the same-cycle issue.
  - Flush outranks Stall.
- Pending_Any = OR of all Rem != 0.
- Reset (async, Reset_n low):
  - All Rem, Late, WBR, last-issue state and Fwd_Sel_EX go to 0.
  - Outputs: Issue = ID_Valid, PC_Enable = 1, IF_ID_Enable = 1, ID_Control_NOP = 0, Pending_Any = 0.
- Reset asserted mid-countdown abandons all tracking; the pipeline is flushed externally.

Decomposition:
- Shared package hazard_pkg holds:
  - CLASS_ALU/LOAD/MULDIV encodings.
  - FWD_RF = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01 (same encoding as the existing forwarding muxes).
  - The latency clamp function.
- One sub-module, hazard_sb_entry: a single register's Rem/Late countdown with load, clear and decrement. It is generated per tracked register.
- Port-check logic is a generate loop in the top level.

Test Plan:
- ALU r3 issue, then ALU reading r3 on port 0 next cycle -> no stall; next-cycle Fwd_Sel_EX[1:0] = 10. One cycle later the read gives 01; two cycles later it gives 00.
- LOAD r5, then ALU using r5 on port 1 -> Stall = 1 for exactly 1 cycle, ID_Control_NOP = 1; then Issue with Fwd_Sel_EX[3:2] = 01.
- MULDIV r7 with ID_Latency = 6, then a consumer of r7 -> stall 4 cycles, then issue with select 10; Pending_Any drops 6 cycles after the MUL issue.
- MULDIV latency 4 issued, then ALU (L=2) two cycles later -> WB-port stall of 1 cycle; ALU to r7 while MUL r7 has Rem = 5 -> WAW stall until Rem <= 2.
- LOAD r9 issued, Flush next cycle -> r9 entry cleared, consumer of r9 in ID issues with select 00; Flush with a stalled ID instruction -> Issue = 0, Fwd_Sel_EX = 0.
- Reset_n pulsed low while MULDIV Rem = 5 -> all state 0 immediately, Pending_Any = 0, no stall after release.
